multi_cycle_controller: RTL and testbench
=========================================

Name: multi_cycle_controller

Overview:
Multi-cycle sequencer for the MIPS-subset CPU. It replaces the single-cycle control decode with a FETCH/DECODE/EXEC/MEM/WB state machine. It drives per-state datapath strobes, including PC and IR writes, register and memory writes, and mux selects. It also handshakes with instruction and data memories that may stall. It sits between the instruction register (op/func inputs) and the shared ALU/register-file/memory datapath.

Parameters:
RA_REG, 5'd31, destination register index for jal
ALU_W, 4, width of ALUctr

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
op  in  6  IR[31:26], stable from DECODE until next FETCH
func  in  6  IR[5:0]
zero  in  1  ALU zero flag, valid in EXEC
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access complete this cycle
imem_req  out  1  instruction fetch request
dmem_req  out  1  data access request
PCWr  out  1  PC write enable
IRWr  out  1  IR write enable
RegWr  out  1  register file write enable
MemWr  out  1  data memory write enable
RegDst  out  2  00 rt, 01 rd, 10 RA_REG
MemtoReg  out  2  00 ALU, 01 memory data, 10 PC+4
PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs (jr)
ALUSrc  out  1  0 rt, 1 immediate
Extop  out  1  1 sign-extend, 0 zero-extend
Shift  out  1  ALU A operand = shamt
ALUctr  out  ALU_W  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sra, 1000 lui
state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
illegal  out  1  one-cycle pulse: unsupported op/func

Behaviour:
- Reset:
  - While reset is high, state=FETCH and every strobe (imem_req, dmem_req, PCWr, IRWr, RegWr, MemWr, illegal) is forced to 0 combinationally.
  - Selects reset to 0.
  - Reset mid-instruction aborts it; no partial writes occur after reset assertion.
- FETCH:
  - imem_req=1.
  - On imem_ready=1: IRWr=1, PCWr=1, PCSrc=00, and the state goes to DECODE.
  - Otherwise hold; no other strobes.
- DECODE: no strobes. Go to EXEC if op/func is legal. Otherwise pulse illegal=1 and return to FETCH; PC has already advanced, so the instruction is skipped.
- Legal set:
  - R-type (op 000000) func: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 000000 sll, 000010 srl, 000011 sra, 001000 jr.
  - I/J ops: 001000 addi, 001100 andi, 001101 ori, 001110 xori, 100011 lw, 101011 sw, 000100 beq, 000101 bne, 001111 lui, 000010 j, 000011 jal.
- EXEC (ALUctr, ALUSrc, Extop, Shift held valid here and in MEM/WB):
  - R-ALU/I-ALU/lui: go to WB.
  - lw/sw: ALUctr=add, ALUSrc=1, Extop=1; go to MEM.
  - beq/bne: ALUctr=sub, PCSrc=01, PCWr=zero (beq) or ~zero (bne); go to FETCH.
  - j: PCWr=1, PCSrc=10; go to FETCH.
  - jal: PCWr=1, PCSrc=10, RegWr=1, RegDst=10, MemtoReg=10; go to FETCH.
  - jr: PCWr=1, PCSrc=11; go to FETCH.
- Extend and shift selects:
  - Extop=1 for addi/lw/sw/beq/bne; 0 for andi/ori/xori/lui.
  - Shift=1 only for sll/srl/sra.
- MEM:
  - dmem_req=1. For sw, MemWr=1 is held until dmem_ready.
  - On dmem_ready: sw goes to FETCH; lw goes to WB.
  - Hold otherwise.
- WB: RegWr=1 for exactly one cycle, then FETCH.
  - R-type: RegDst=01, MemtoReg=00.
  - I-type: RegDst=00, MemtoReg=00.
  - lw: RegDst=00, MemtoReg=01.
- Latency with zero wait states:
  - R/I-ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - branch/jump: 3 cycles.
  - Each wait cycle adds 1.
- Strobe multiplicity: at most one of PCWr/RegWr/MemWr-complete per instruction per state. RegWr never asserts in FETCH, DECODE or MEM.

Optional Feature:
INSTRET_CNT_EN
- Defined:
  - Adds output ports instret[31:0] and cycles[31:0], both cleared by reset.
  - cycles increments every clock out of reset.
  - instret increments on the final cycle of each legal instruction (transition into FETCH, excluding the illegal path).
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. add (op 000000, func 100000), imem_ready/dmem_ready tied 1 -> state sequence 0,1,2,4,0; RegWr=1 only in WB with RegDst=01, ALUctr=0000.
2. lw (op 100011), dmem_ready low for 3 MEM cycles -> dmem_req high 4 cycles; WB RegWr=1, MemtoReg=01; total 8 cycles.
3. beq (op 000100) with zero=1 then zero=0 -> PCWr=1, PCSrc=01 in EXEC for the first; PCWr=0 for the second. bne gives the inverse.
4. jal (op 000011) -> in EXEC: PCWr=1, PCSrc=10, RegWr=1, RegDst=10, MemtoReg=10; back to FETCH after 3 cycles.
5. op 111111 -> illegal pulses 1 cycle in DECODE; no RegWr/MemWr; next state FETCH.
6. Assert reset during MEM of sw with MemWr=1 -> MemWr drops the same cycle, state=0. After release, FETCH with imem_req=1. With INSTRET_CNT_EN, instret=0.

Source files
------------

// File: rtl/multi_cycle_controller.sv
// ============================================================================
// multi_cycle_controller
// ----------------------------------------------------------------------------
// Multi-cycle sequencer for the MIPS-subset CPU. It steps each instruction
// through FETCH / DECODE / EXEC / MEM / WB and drives the datapath strobes and
// mux selects for each state. Both memories may stall through their ready
// handshakes.
//
// Optional build macro: INSTRET_CNT_EN adds the instret/cycles counter ports.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high
//   op, func    IR[31:26] / IR[5:0], stable from DECODE until next FETCH
//   zero        ALU zero flag (valid in EXEC)
//   imem_ready  instruction word valid this cycle
//   dmem_ready  data access complete this cycle
//   imem_req    instruction fetch request (FETCH)
//   dmem_req    data access request (MEM)
//   PCWr, IRWr, RegWr, MemWr   write enables
//   RegDst      00 rt, 01 rd, 10 RA_REG
//   MemtoReg    00 ALU, 01 memory data, 10 PC+4
//   PCSrc       00 PC+4, 01 branch target, 10 jump target, 11 rs
//   ALUSrc      0 rt, 1 immediate
//   Extop       1 sign-extend, 0 zero-extend
//   Shift       ALU A operand = shamt
//   ALUctr      ALU operation code
//   state       FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
//   illegal     one-cycle pulse in DECODE for an unsupported op/func
//   instret, cycles (INSTRET_CNT_EN only) retired-instruction / clock counts
// ============================================================================
module multi_cycle_controller #(
    parameter logic [4:0] RA_REG = 5'd31,   // register selected by RegDst=10
    parameter int         ALU_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RegWr,
    output logic             MemWr,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       PCSrc,
    output logic             ALUSrc,
    output logic             Extop,
    output logic             Shift,
    output logic [ALU_W-1:0] ALUctr,
    output logic [2:0]       state,
    output logic             illegal
`ifdef INSTRET_CNT_EN
    ,
    output logic [31:0]      instret,
    output logic [31:0]      cycles
`endif
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_XOR = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_SLL = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_SRL = ALU_W'(6);
    localparam logic [ALU_W-1:0] ALU_SRA = ALU_W'(7);
    localparam logic [ALU_W-1:0] ALU_LUI = ALU_W'(8);

    logic [2:0] state_reg;
    logic [2:0] state_next;

    // ------------------------------------------------------------------
    // Instruction decode (pure function of op/func)
    // ------------------------------------------------------------------
    logic             dec_legal;
    logic             dec_r_alu;   // R-type ALU op, writes rd
    logic             dec_i_alu;   // I-type ALU op incl. lui, writes rt
    logic             dec_lw;
    logic             dec_sw;
    logic             dec_beq;
    logic             dec_bne;
    logic             dec_j;
    logic             dec_jal;
    logic             dec_jr;
    logic [ALU_W-1:0] dec_alu;
    logic             dec_alu_src;
    logic             dec_ext;
    logic             dec_shift;

    always_comb begin
        dec_legal   = 1'b1;
        dec_r_alu   = 1'b0;
        dec_i_alu   = 1'b0;
        dec_lw      = 1'b0;
        dec_sw      = 1'b0;
        dec_beq     = 1'b0;
        dec_bne     = 1'b0;
        dec_j       = 1'b0;
        dec_jal     = 1'b0;
        dec_jr      = 1'b0;
        dec_alu     = ALU_ADD;
        dec_alu_src = 1'b0;
        dec_ext     = 1'b0;
        dec_shift   = 1'b0;
        case (op)
            6'b000000: begin
                dec_r_alu = 1'b1;
                case (func)
                    6'b100000: dec_alu = ALU_ADD;
                    6'b100010: dec_alu = ALU_SUB;
                    6'b100100: dec_alu = ALU_AND;
                    6'b100101: dec_alu = ALU_OR;
                    6'b100110: dec_alu = ALU_XOR;
                    6'b000000: begin dec_alu = ALU_SLL; dec_shift = 1'b1; end
                    6'b000010: begin dec_alu = ALU_SRL; dec_shift = 1'b1; end
                    6'b000011: begin dec_alu = ALU_SRA; dec_shift = 1'b1; end
                    6'b001000: begin dec_r_alu = 1'b0; dec_jr = 1'b1; end
                    default:   begin dec_r_alu = 1'b0; dec_legal = 1'b0; end
                endcase
            end
            6'b001000: begin dec_i_alu = 1'b1; dec_alu = ALU_ADD; dec_alu_src = 1'b1; dec_ext = 1'b1; end
            6'b001100: begin dec_i_alu = 1'b1; dec_alu = ALU_AND; dec_alu_src = 1'b1; end
            6'b001101: begin dec_i_alu = 1'b1; dec_alu = ALU_OR;  dec_alu_src = 1'b1; end
            6'b001110: begin dec_i_alu = 1'b1; dec_alu = ALU_XOR; dec_alu_src = 1'b1; end
            6'b001111: begin dec_i_alu = 1'b1; dec_alu = ALU_LUI; dec_alu_src = 1'b1; end
            6'b100011: begin dec_lw    = 1'b1; dec_alu = ALU_ADD; dec_alu_src = 1'b1; dec_ext = 1'b1; end
            6'b101011: begin dec_sw    = 1'b1; dec_alu = ALU_ADD; dec_alu_src = 1'b1; dec_ext = 1'b1; end
            6'b000100: begin dec_beq   = 1'b1; dec_alu = ALU_SUB; dec_ext = 1'b1; end
            6'b000101: begin dec_bne   = 1'b1; dec_alu = ALU_SUB; dec_ext = 1'b1; end
            6'b000010: dec_j   = 1'b1;
            6'b000011: dec_jal = 1'b1;
            default:   dec_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next state and per-state outputs (before reset gating)
    // ------------------------------------------------------------------
    logic             imem_req_c, dmem_req_c, pc_wr_c, ir_wr_c, reg_wr_c, mem_wr_c, illegal_c;
    logic [1:0]       reg_dst_c, mem_to_reg_c, pc_src_c;
    logic             alu_src_c, ext_c, shift_c;
    logic [ALU_W-1:0] alu_c;

    always_comb begin
        state_next   = state_reg;
        imem_req_c   = 1'b0;
        dmem_req_c   = 1'b0;
        pc_wr_c      = 1'b0;
        ir_wr_c      = 1'b0;
        reg_wr_c     = 1'b0;
        mem_wr_c     = 1'b0;
        illegal_c    = 1'b0;
        reg_dst_c    = 2'b00;
        mem_to_reg_c = 2'b00;
        pc_src_c     = 2'b00;
        alu_src_c    = 1'b0;
        ext_c        = 1'b0;
        shift_c      = 1'b0;
        alu_c        = ALU_ADD;

        // ALU selects stay valid through EXEC, MEM and WB so the operands
        // do not change under a stalled data access or the write-back.
        if (state_reg == S_EXEC || state_reg == S_MEM || state_reg == S_WB) begin
            alu_src_c = dec_alu_src;
            ext_c     = dec_ext;
            shift_c   = dec_shift;
            alu_c     = dec_alu;
        end

        case (state_reg)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_wr_c    = 1'b1;
                    pc_wr_c    = 1'b1;      // PC <= PC+4 (PCSrc 00)
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    state_next = S_EXEC;
                end else begin
                    // PC already advanced in FETCH, so the word is skipped.
                    illegal_c  = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXEC: begin
                if (dec_r_alu || dec_i_alu) begin
                    state_next = S_WB;
                end else if (dec_lw || dec_sw) begin
                    state_next = S_MEM;
                end else if (dec_beq || dec_bne) begin
                    pc_src_c   = 2'b01;
                    pc_wr_c    = dec_beq ? zero : ~zero;
                    state_next = S_FETCH;
                end else if (dec_j) begin
                    pc_src_c   = 2'b10;
                    pc_wr_c    = 1'b1;
                    state_next = S_FETCH;
                end else if (dec_jal) begin
                    // Link is written in the same cycle the PC jumps; the
                    // register file sees PC+4 of the jal itself.
                    pc_src_c     = 2'b10;
                    pc_wr_c      = 1'b1;
                    reg_wr_c     = 1'b1;
                    reg_dst_c    = 2'b10;
                    mem_to_reg_c = 2'b10;
                    state_next   = S_FETCH;
                end else begin
                    pc_src_c   = 2'b11;     // jr
                    pc_wr_c    = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                mem_wr_c   = dec_sw;
                if (dmem_ready) begin
                    state_next = dec_sw ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                reg_wr_c     = 1'b1;
                reg_dst_c    = dec_r_alu ? 2'b01 : 2'b00;
                mem_to_reg_c = dec_lw ? 2'b01 : 2'b00;
                state_next   = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Reset masks every output combinationally so an aborted instruction
    // cannot complete a write in the cycle reset rises.
    always_comb begin
        state    = reset ? S_FETCH : state_reg;
        imem_req = ~reset & imem_req_c;
        dmem_req = ~reset & dmem_req_c;
        PCWr     = ~reset & pc_wr_c;
        IRWr     = ~reset & ir_wr_c;
        RegWr    = ~reset & reg_wr_c;
        MemWr    = ~reset & mem_wr_c;
        illegal  = ~reset & illegal_c;
        RegDst   = reset ? 2'b00 : reg_dst_c;
        MemtoReg = reset ? 2'b00 : mem_to_reg_c;
        PCSrc    = reset ? 2'b00 : pc_src_c;
        ALUSrc   = ~reset & alu_src_c;
        Extop    = ~reset & ext_c;
        Shift    = ~reset & shift_c;
        ALUctr   = reset ? ALU_ADD : alu_c;
    end

`ifdef INSTRET_CNT_EN
    logic [31:0] instret_reg;
    logic [31:0] cycles_reg;
    logic        retire;

    // Retirement is the step back to FETCH from EXEC/MEM/WB; the illegal
    // path leaves from DECODE and is therefore not counted.
    assign retire = (state_reg == S_EXEC || state_reg == S_MEM || state_reg == S_WB)
                    && (state_next == S_FETCH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_reg <= 32'd0;
            cycles_reg  <= 32'd0;
        end else begin
            cycles_reg <= cycles_reg + 32'd1;
            if (retire) begin
                instret_reg <= instret_reg + 32'd1;
            end
        end
    end

    assign instret = instret_reg;
    assign cycles  = cycles_reg;
`endif

endmodule

// File: tb/tb_multi_cycle_controller.sv
module tb_multi_cycle_controller;

    localparam logic [5:0] OP_R = 6'h00, F_ADD = 6'h20, F_SRA = 6'h03, F_JR = 6'h08;
    localparam logic [5:0] OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] BAD = 6'h3f;

    // strobe vector order: {imem_req, dmem_req, PCWr, IRWr, RegWr, MemWr}
    localparam logic [5:0] S_NONE = 6'b000000, S_FWAIT = 6'b100000, S_FGO = 6'b101100;
    localparam logic [5:0] S_WBW = 6'b000010, S_PCW = 6'b001000, S_JAL = 6'b001010;
    localparam logic [5:0] S_MEMW = 6'b010001, S_MEMR = 6'b010000;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, func;
    logic       zero, imem_ready, dmem_ready;
    logic       imem_req, dmem_req, PCWr, IRWr, RegWr, MemWr;
    logic [1:0] RegDst, MemtoReg, PCSrc;
    logic       ALUSrc, Extop, Shift;
    logic [3:0] ALUctr;
    logic [2:0] state;
    logic       illegal;
`ifdef INSTRET_CNT_EN
    logic [31:0] instret, cycles;
`endif

    always #5 clk = ~clk;

    multi_cycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .PCWr(PCWr), .IRWr(IRWr),
        .RegWr(RegWr), .MemWr(MemWr), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .PCSrc(PCSrc), .ALUSrc(ALUSrc), .Extop(Extop), .Shift(Shift),
        .ALUctr(ALUctr), .state(state), .illegal(illegal)
`ifdef INSTRET_CNT_EN
        , .instret(instret), .cycles(cycles)
`endif
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [5:0] op, func;
        logic       zero, ir, dr;
        logic [2:0] st;
        logic [5:0] stb;
        logic       ill;
        logic [1:0] rd, m2r, pcs;
        logic       as, ex, sh;
        logic [3:0] alu;
    } vec_t;

    vec_t vq[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(string name, logic rst, logic [5:0] o, logic [5:0] f,
                                logic z, logic ir, logic dr, logic [2:0] st, logic [5:0] stb,
                                logic ill, logic [1:0] rd, logic [1:0] m2r, logic [1:0] pcs,
                                logic as, logic ex, logic sh, logic [3:0] alu);
        vec_t v;
        v.name = name; v.rst = rst; v.op = o; v.func = f; v.zero = z; v.ir = ir; v.dr = dr;
        v.st = st; v.stb = stb; v.ill = ill; v.rd = rd; v.m2r = m2r; v.pcs = pcs;
        v.as = as; v.ex = ex; v.sh = sh; v.alu = alu;
        return v;
    endfunction

    // FETCH (ready) + DECODE rows shared by every legal instruction
    task automatic fd(string n, logic [5:0] o, logic [5:0] f);
        vq.push_back(mk({n, "_fetch"}, 0, o, f, 0, 1, 1, 3'd0, S_FGO, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4'h0));
        vq.push_back(mk({n, "_dec"},   0, o, f, 0, 1, 1, 3'd1, S_NONE, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4'h0));
    endtask

    task automatic apply(input vec_t v);
        logic [5:0] stb_act;
        logic       is_jmp, ok;
        @(negedge clk);
        reset = v.rst; op = v.op; func = v.func; zero = v.zero;
        imem_ready = v.ir; dmem_ready = v.dr;
        #2;
        stb_act = {imem_req, dmem_req, PCWr, IRWr, RegWr, MemWr};
        is_jmp  = (v.op == OP_J) || (v.op == OP_JAL) || (v.op == OP_R && v.func == F_JR);
        ok = (state == v.st) && (stb_act == v.stb) && (illegal == v.ill);
        // selects are only checked where they steer something
        if (v.rst || v.stb[3]) ok = ok && (PCSrc == v.pcs);
        if (v.rst || v.stb[1]) ok = ok && (RegDst == v.rd) && (MemtoReg == v.m2r);
        if (v.rst || ((v.st >= 3'd2) && (v.st <= 3'd4) && !is_jmp))
            ok = ok && (ALUctr == v.alu) && (ALUSrc == v.as) && (Extop == v.ex) && (Shift == v.sh);
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL %s: got st=%0d stb=%b ill=%b rd=%b m2r=%b pcs=%b as=%b ex=%b sh=%b alu=%h ; want st=%0d stb=%b ill=%b rd=%b m2r=%b pcs=%b as=%b ex=%b sh=%b alu=%h",
                     v.name, state, stb_act, illegal, RegDst, MemtoReg, PCSrc, ALUSrc, Extop, Shift, ALUctr,
                     v.st, v.stb, v.ill, v.rd, v.m2r, v.pcs, v.as, v.ex, v.sh, v.alu);
        end else begin
            $display("vec %0d %s ok", n_vec, v.name);
        end
    endtask

    task automatic check(string n, int got, int want);
        n_vec++;
        if (got != want) begin
            n_miss++;
            $display("FAIL %s: got %0d want %0d", n, got, want);
        end else begin
            $display("vec %0d %s ok (%0d)", n_vec, n, got);
        end
    endtask

    initial begin
        int  cyc, dreq, memseen;
        logic wbok, done;
        reset = 1; op = OP_R; func = F_ADD; zero = 0; imem_ready = 1; dmem_ready = 1;

        // ---------------- vector table ----------------
        vq.push_back(mk("reset", 1, OP_R, F_ADD, 0, 1, 1, 3'd0, S_NONE, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4'h0));
        vq.push_back(mk("add_fwait", 0, OP_R, F_ADD, 0, 0, 1, 3'd0, S_FWAIT, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4'h0));
        fd("add", OP_R, F_ADD);
        vq.push_back(mk("add_exec", 0, OP_R, F_ADD, 0, 1, 1, 3'd2, S_NONE, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4'h0));
        vq.push_back(mk("add_wb",   0, OP_R, F_ADD, 0, 1, 1, 3'd4, S_WBW,  0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 4'h0));
        fd("sra", OP_R, F_SRA);
        vq.push_back(mk("sra_exec", 0, OP_R, F_SRA, 0, 1, 1, 3'd2, S_NONE, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 4'h7));
        vq.push_back(mk("sra_wb",   0, OP_R, F_SRA, 0, 1, 1, 3'd4, S_WBW,  0, 2'b01, 2'b00, 2'b00, 0, 0, 1, 4'h7));
        fd("ori", OP_ORI, 6'h00);
        vq.push_back(mk("ori_exec", 0, OP_ORI, 6'h00, 0, 1, 1, 3'd2, S_NONE, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 4'h3));
        vq.push_back(mk("ori_wb",   0, OP_ORI, 6'h00, 0, 1, 1, 3'd4, S_WBW,  0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 4'h3));
        fd("beq1", OP_BEQ, 6'h00);
        vq.push_back(mk("beq_z1_exec", 0, OP_BEQ, 6'h00, 1, 1, 1, 3'd2, S_PCW,  0, 2'b00, 2'b00, 2'b01, 0, 1, 0, 4'h1));
        fd("beq0", OP_BEQ, 6'h00);
        vq.push_back(mk("beq_z0_exec", 0, OP_BEQ, 6'h00, 0, 1, 1, 3'd2, S_NONE, 0, 2'b00, 2'b00, 2'b01, 0, 1, 0, 4'h1));
        fd("bne0", OP_BNE, 6'h00);
        vq.push_back(mk("bne_z0_exec", 0, OP_BNE, 6'h00, 0, 1, 1, 3'd2, S_PCW,  0, 2'b00, 2'b00, 2'b01, 0, 1, 0, 4'h1));
        fd("bne1", OP_BNE, 6'h00);
        vq.push_back(mk("bne_z1_exec", 0, OP_BNE, 6'h00, 1, 1, 1, 3'd2, S_NONE, 0, 2'b00, 2'b00, 2'b01, 0, 1, 0, 4'h1));
        fd("jal", OP_JAL, 6'h00);
        vq.push_back(mk("jal_exec", 0, OP_JAL, 6'h00, 0, 1, 1, 3'd2, S_JAL, 0, 2'b10, 2'b10, 2'b10, 0, 0, 0, 4'h0));
        fd("jr", OP_R, F_JR);
        vq.push_back(mk("jr_exec", 0, OP_R, F_JR, 0, 1, 1, 3'd2, S_PCW, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 4'h0));
        fd("j", OP_J, 6'h00);
        vq.push_back(mk("j_exec", 0, OP_J, 6'h00, 0, 1, 1, 3'd2, S_PCW, 0, 2'b00, 2'b00, 2'b10, 0, 0, 0, 4'h0));
        vq.push_back(mk("badop_fetch", 0, BAD, 6'h00, 0, 1, 1, 3'd0, S_FGO,  0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4'h0));
        vq.push_back(mk("badop_dec",   0, BAD, 6'h00, 0, 1, 1, 3'd1, S_NONE, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4'h0));
        vq.push_back(mk("badfn_fetch", 0, OP_R, BAD, 0, 1, 1, 3'd0, S_FGO,  0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4'h0));
        vq.push_back(mk("badfn_dec",   0, OP_R, BAD, 0, 1, 1, 3'd1, S_NONE, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4'h0));
        fd("lw", OP_LW, 6'h00);
        vq.push_back(mk("lw_exec", 0, OP_LW, 6'h00, 0, 1, 1, 3'd2, S_NONE, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 4'h0));
        vq.push_back(mk("lw_mem",  0, OP_LW, 6'h00, 0, 1, 1, 3'd3, S_MEMR, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 4'h0));
        vq.push_back(mk("lw_wb",   0, OP_LW, 6'h00, 0, 1, 1, 3'd4, S_WBW,  0, 2'b00, 2'b01, 2'b00, 1, 1, 0, 4'h0));
        fd("lui", OP_LUI, 6'h00);
        vq.push_back(mk("lui_exec", 0, OP_LUI, 6'h00, 0, 1, 1, 3'd2, S_NONE, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 4'h8));
        vq.push_back(mk("lui_wb",   0, OP_LUI, 6'h00, 0, 1, 1, 3'd4, S_WBW,  0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 4'h8));
        fd("sw", OP_SW, 6'h00);
        vq.push_back(mk("sw_exec",  0, OP_SW, 6'h00, 0, 1, 0, 3'd2, S_NONE, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 4'h0));
        vq.push_back(mk("sw_mem_w1",0, OP_SW, 6'h00, 0, 1, 0, 3'd3, S_MEMW, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 4'h0));
        vq.push_back(mk("sw_mem_w2",0, OP_SW, 6'h00, 0, 1, 0, 3'd3, S_MEMW, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 4'h0));
        vq.push_back(mk("sw_abort", 1, OP_SW, 6'h00, 0, 1, 0, 3'd0, S_NONE, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4'h0));
        fd("sw2", OP_SW, 6'h00);
        vq.push_back(mk("sw2_exec", 0, OP_SW, 6'h00, 0, 1, 1, 3'd2, S_NONE, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 4'h0));
        vq.push_back(mk("sw2_mem",  0, OP_SW, 6'h00, 0, 1, 1, 3'd3, S_MEMW, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 4'h0));
        vq.push_back(mk("sw2_done", 0, OP_R, F_ADD, 0, 0, 1, 3'd0, S_FWAIT, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4'h0));

        for (int i = 0; i < vq.size(); i++) apply(vq[i]);

        // ---------------- lw with three data wait states ----------------
        cyc = 0; dreq = 0; memseen = 0; wbok = 0; done = 0;
        @(negedge clk);
        reset = 0; op = OP_LW; func = 6'h00; imem_ready = 1; dmem_ready = 0;
        for (int k = 0; k < 50; k++) begin
            dmem_ready = (state == 3'd3) && (memseen >= 3);
            #2;
            if (dmem_req) dreq++;
            if (state == 3'd3) memseen++;
            if (state == 3'd4 && RegWr && MemtoReg == 2'b01) wbok = 1;
            cyc++;
            @(posedge clk); #1;
            if (state == 3'd0) begin done = 1; break; end
            @(negedge clk);
        end
        check("lw_wait_done", int'(done), 1);
        check("lw_wait_cycles", cyc, 8);
        check("lw_wait_dmem_req", dreq, 4);
        check("lw_wait_wb", int'(wbok), 1);

`ifdef INSTRET_CNT_EN
        // ---------------- counters ----------------
        @(negedge clk);
        reset = 1; #2;
        check("cnt_rst_instret", int'(instret), 0);
        check("cnt_rst_cycles", int'(cycles), 0);
        @(negedge clk);
        reset = 0; op = OP_R; func = F_ADD; imem_ready = 1; dmem_ready = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        op = BAD;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        check("cnt_instret", int'(instret), 1);
        check("cnt_cycles", int'(cycles), 6);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
